// File: rtl/ps2_rx_frame_if.sv
// PS/2 receive bundle: raw device pins in, decoded scan code and status pulses out.
interface ps2_rx_frame_if;
  logic       ps2_clk;
  logic       ps2_dat;
  logic [7:0] scan_code;
  logic       scan_code_ready;
  logic       scan_code_error;

  modport master (input ps2_clk, ps2_dat, output scan_code, scan_code_ready, scan_code_error);
  modport slave  (output ps2_clk, ps2_dat, input scan_code, scan_code_ready, scan_code_error);
endinterface

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: sync + glitch filter on the PS/2 clock,
// 11-bit frame deserializer with odd-parity/stop check and inter-edge timeout.
module ps2_rx_frame #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic           clk,
  input  logic           reset,
  ps2_rx_frame_if.master bus
);
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic                  clk_m, clk_s, dat_m, dat_s;
  logic [FILTER_LEN-1:0] hist;
  logic                  filt, filt_prev, fall;

  state_t                state;
  logic [2:0]            bit_cnt;
  logic [7:0]            shreg;
  logic                  par;
  logic [TW-1:0]         to_cnt;
  logic [7:0]            code_q;
  logic                  rdy_q, err_q;

  // Idle-high lines: everything in the front end resets to 1 so release never fakes an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_m     <= 1'b1;
      clk_s     <= 1'b1;
      dat_m     <= 1'b1;
      dat_s     <= 1'b1;
      hist      <= '1;
      filt      <= 1'b1;
      filt_prev <= 1'b1;
    end else begin
      clk_m     <= bus.ps2_clk;
      clk_s     <= clk_m;
      dat_m     <= bus.ps2_dat;
      dat_s     <= dat_m;
      hist      <= {hist[FILTER_LEN-2:0], clk_s};
      if (hist == '0)      filt <= 1'b0;
      else if (hist == '1) filt <= 1'b1;
      filt_prev <= filt;
    end
  end

  assign fall = filt_prev & ~filt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      par     <= 1'b0;
      to_cnt  <= '0;
      code_q  <= '0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      err_q <= 1'b0;
      if (state == IDLE || fall) to_cnt <= '0;
      else                       to_cnt <= to_cnt + 1'b1;

      case (state)
        IDLE: if (fall && !dat_s) begin
          bit_cnt <= '0;
          state   <= DATA;
        end
        DATA: if (fall) begin
          shreg   <= {dat_s, shreg[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state <= PARITY;
        end
        PARITY: if (fall) begin
          par   <= dat_s;
          state <= STOP;
        end
        STOP: if (fall) begin
          if (dat_s && (^shreg ^ par)) begin
            code_q <= shreg;
            rdy_q  <= 1'b1;
          end else begin
            err_q  <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // A fall in the expiry cycle is serviced above instead of timing out.
      if (state != IDLE && !fall && to_cnt == TO_LAST) begin
        state <= IDLE;
        err_q <= 1'b1;
      end
    end
  end

  assign bus.scan_code       = code_q;
  assign bus.scan_code_ready = rdy_q;
  assign bus.scan_code_error = err_q;
endmodule

// File: tb/tb_ps2_rx_frame.sv
// Randomized scoreboard bench for ps2_rx_frame: a frame-level model predicts each
// ready/error pulse, its scan_code and its latency from the last PS/2 clock low.
module tb_ps2_rx_frame;
  localparam int FL = 4;
  localparam int TO = 200;

  logic clk = 1'b0;
  logic reset = 1'b0;
  ps2_rx_frame_if bus();

  ps2_rx_frame #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         err;
    logic [7:0] code;
    int         lat;
  } exp_t;

  exp_t       q[$];
  bit         pend[$];
  logic [7:0] model_code = 8'h00;
  int         checks = 0, failures = 0;
  int         cyc = 0, last_low = 0;
  bit         pr = 1'b0, pe = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Frame model: collects the data values seen at each effective falling edge.
  function automatic void model_bit(input bit b);
    logic [7:0] d;
    bit good;
    if (pend.size() == 0 && b) return;
    pend.push_back(b);
    if (pend.size() == 11) begin
      for (int i = 0; i < 8; i++) d[i] = pend[1+i];
      good = pend[10] && ((^d) ^ pend[9]);
      if (good) model_code = d;
      q.push_back('{!good, model_code, 3 + FL});
      pend.delete();
    end
  endfunction

  function automatic void model_timeout();
    if (pend.size() != 0) begin
      q.push_back('{1'b1, model_code, 3 + FL + TO});
      pend.delete();
    end
  endfunction

  function automatic void model_reset();
    pend.delete();
    model_code = 8'h00;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One PS/2 bit: data set at mid-high, 40-cycle low, 20-cycle trailing high.
  // ghi = short high glitch inside the low phase; glo = low glitch in the trailing high.
  task automatic send_bit(input bit b, input int glo, input int ghi);
    bus.ps2_dat = b;
    tick(20);
    bus.ps2_clk = 1'b0; last_low = cyc + 1; model_bit(b);
    if (ghi > 0) begin
      tick(15); bus.ps2_clk = 1'b1; tick(ghi); bus.ps2_clk = 1'b0; tick(25 - ghi);
    end else tick(40);
    bus.ps2_clk = 1'b1;
    if (glo > 0) begin
      tick(10);
      bus.ps2_clk = 1'b0; last_low = cyc + 1;
      if (glo >= FL) model_bit(b);
      tick(glo); bus.ps2_clk = 1'b1; tick(10 - glo);
    end else tick(20);
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] d, input bit pflip, input bit sbad);
    return {~sbad, (~^d) ^ pflip, d, 1'b0};
  endfunction

  task automatic send_frame(input logic [7:0] d, input bit pflip, input bit sbad,
                            input int gbit, input int glo, input int ghi, input int nbits);
    logic [10:0] fr;
    fr = mk_frame(d, pflip, sbad);
    for (int k = 0; k < nbits; k++)
      send_bit(fr[k], (k == gbit) ? glo : 0, (k == gbit) ? ghi : 0);
  endtask

  // Monitor: pops one expectation per output pulse.
  always @(negedge clk) begin : mon
    exp_t e;
    if (reset) begin
      if (pr) chk("ready_width", int'(bus.scan_code_ready), 0);
      if (pe) chk("error_width", int'(bus.scan_code_error), 0);
      if (bus.scan_code_ready || bus.scan_code_error) begin
        chk("pulse_exclusive", int'(bus.scan_code_ready & bus.scan_code_error), 0);
        if (q.size() == 0) chk("unexpected_pulse_pending", q.size(), 1);
        else begin
          e = q.pop_front();
          chk("pulse_is_error", int'(bus.scan_code_error), int'(e.err));
          chk("scan_code", int'(bus.scan_code), int'(e.code));
          chk("pulse_latency", cyc - last_low, e.lat);
        end
      end
      pr <= bus.scan_code_ready;
      pe <= bus.scan_code_error;
    end else begin
      pr <= 1'b0;
      pe <= 1'b0;
    end
  end

  logic [7:0] rd;
  int         mode, nb, gb;

  initial begin
    bus.ps2_clk = 1'b1;
    bus.ps2_dat = 1'b1;
    tick(4);
    chk("reset_scan_code", int'(bus.scan_code), 0);
    chk("reset_ready", int'(bus.scan_code_ready), 0);
    chk("reset_error", int'(bus.scan_code_error), 0);
    reset = 1'b1;
    tick(30);

    // Bad parity, then bad stop bit: two errors, code stays 00.
    send_frame(8'h1C, 1'b1, 1'b0, -1, 0, 0, 11);
    send_frame(8'h1C, 1'b0, 1'b1, -1, 0, 0, 11);
    bus.ps2_dat = 1'b1; tick(60);
    // Single good frame, then back-to-back F0 / 1C.
    send_frame(8'h1C, 1'b0, 1'b0, -1, 0, 0, 11);
    send_frame(8'hF0, 1'b0, 1'b0, -1, 0, 0, 11);
    send_frame(8'h1C, 1'b0, 1'b0, -1, 0, 0, 11);
    tick(60);
    // Glitches next to data bit 3 of 5A: short ones vanish, a full-length one adds a bit.
    send_frame(8'h5A, 1'b0, 1'b0, 3, FL - 1, 0, 11);
    send_frame(8'h5A, 1'b0, 1'b0, 5, 0, FL - 1, 11);
    send_frame(8'h5A, 1'b0, 1'b0, 3, FL, 0, 11);
    model_timeout(); tick(300);
    // Start + 5 data bits then silence, followed by a clean 29.
    send_frame(8'hA5, 1'b0, 1'b0, -1, 0, 0, 6);
    bus.ps2_dat = 1'b1; model_timeout(); tick(260);
    send_frame(8'h29, 1'b0, 1'b0, -1, 0, 0, 11);
    tick(40);
    // Reset during data bit 4 aborts silently; then 66 is received.
    send_frame(8'h33, 1'b0, 1'b0, -1, 0, 0, 5);
    bus.ps2_dat = 1'b1; tick(5);
    reset = 1'b0; model_reset(); tick(3);
    chk("midreset_scan_code", int'(bus.scan_code), 0);
    chk("midreset_ready", int'(bus.scan_code_ready), 0);
    chk("midreset_error", int'(bus.scan_code_error), 0);
    reset = 1'b1; tick(300);
    send_frame(8'h66, 1'b0, 1'b0, -1, 0, 0, 11);
    tick(40);

    for (int i = 0; i < 16; i++) begin
      rd   = 8'($urandom);
      mode = $urandom_range(0, 3);
      gb   = $urandom_range(0, 10);
      if (mode == 3) begin
        nb = $urandom_range(1, 10);
        send_frame(rd, 1'b0, 1'b0, -1, 0, 0, nb);
        bus.ps2_dat = 1'b1; model_timeout(); tick(260);
      end else begin
        send_frame(rd, mode == 1, mode == 2, gb, $urandom_range(0, FL - 1),
                   $urandom_range(0, FL - 1), 11);
        if ($urandom_range(0, 1) == 1) begin
          bus.ps2_dat = 1'b1; tick($urandom_range(1, 100));
        end
      end
    end

    bus.ps2_dat = 1'b1;
    model_timeout();
    tick(300);
    chk("scoreboard_drained", q.size(), 0);
    chk("final_scan_code", int'(bus.scan_code), int'(model_code));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
